pc_fetch_sequencer: RTL and testbench

//  Sequences the 5-bit program counter and the instruction-fetch handshake for the 32-bit core.
//  - Holds the current PC and issues one fetch request per instruction to instruction memory.
//  - Chooses the next PC each instruction: increment, branch redirect, stall hold or halt.
//  - Sits between the decode/branch unit and instruction memory.
//  - Replaces the free-running PC incrementer with an FSM-controlled one.

---
 rtl/pc_fetch_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Purpose
//   Owns the program counter of the 32-bit core and runs the instruction-fetch
//   handshake with instruction memory. One fetch request is issued per
//   instruction. After each delivered instruction the FSM picks the next PC:
//   sequential increment, branch redirect, stall hold or halt. A fetch that
//   is never acknowledged ends in a sticky ERROR state that only reset clears.
//
// Parameters
//   ADDR_W    PC / instruction address width
//   RESET_PC  PC loaded on reset and on every start from IDLE or HALTED
//   MAX_WAIT  consecutive un-acked request cycles before timeout (>= 1)
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   start        in   begin execution at RESET_PC (honoured in IDLE/HALTED)
//   halt         in   stop after the current instruction (ISSUE/HOLD)
//   stall        in   hold the PC and issue no new fetch (ISSUE/HOLD)
//   br_taken     in   redirect the next fetch to br_target (ISSUE/HOLD)
//   br_target    in   branch/jump destination, used verbatim
//   imem_ack     in   memory accepted and returned the request (FETCH only)
//   imem_req     out  fetch request level, held until acknowledged
//   imem_addr    out  fetch address, always equal to pc
//   pc           out  current program counter
//   instr_valid  out  one-cycle pulse: the instruction at pc was delivered
//   busy         out  high in FETCH, ISSUE or HOLD
//   timeout_err  out  sticky fetch-timeout flag
// -----------------------------------------------------------------------------
module pc_fetch_sequencer #(
   parameter int unsigned       ADDR_W   = 5,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              halt,
   input  logic              stall,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              imem_ack,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [ADDR_W-1:0] pc,
   output logic              instr_valid,
   output logic              busy,
   output logic              timeout_err
);

   // The wait counter only has to reach MAX_WAIT-1, so $clog2(MAX_WAIT) bits
   // are enough; keep at least one bit for the MAX_WAIT == 1 corner.
   localparam int unsigned      CNT_W     = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_HOLD   = 3'd3,
      ST_HALTED = 3'd4,
      ST_ERROR  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

   // -------------------------------------------------------------------------
   // State registers. Reset is asynchronous so that an in-flight request is
   // withdrawn immediately, even in the middle of a fetch.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      wait_cnt_d = wait_cnt_q;

      unique case (state_q)
         ST_IDLE, ST_HALTED: begin
            if (start) begin
               pc_d       = RESET_PC;
               wait_cnt_d = '0;
               state_d    = ST_FETCH;
            end
         end

         ST_FETCH: begin
            if (imem_ack) begin
               wait_cnt_d = '0;
               state_d    = ST_ISSUE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               // This was the MAX_WAIT-th consecutive cycle without an ack.
               wait_cnt_d = '0;
               state_d    = ST_ERROR;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end

         // ISSUE and HOLD share one priority chain: halt beats a branch, and
         // a branch beats a stall, so a redirect arriving mid-stall is taken.
         ST_ISSUE, ST_HOLD: begin
            if (halt) begin
               state_d = ST_HALTED;
            end else if (br_taken) begin
               pc_d       = br_target;
               wait_cnt_d = '0;
               state_d    = ST_FETCH;
            end else if (stall) begin
               state_d = ST_HOLD;
            end else begin
               // Natural ADDR_W-bit wrap: the top address rolls over to 0.
               pc_d       = pc_q + ADDR_W'(1);
               wait_cnt_d = '0;
               state_d    = ST_FETCH;
            end
         end

         ST_ERROR: begin
            // Terminal until reset; start is deliberately not honoured here.
            state_d = ST_ERROR;
         end

         default: begin
            state_d    = ST_IDLE;
            pc_d       = RESET_PC;
            wait_cnt_d = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs are pure decodes of the registered state, so none of them
   // depends combinationally on an input.
   // -------------------------------------------------------------------------
   assign imem_req    = (state_q == ST_FETCH);
   assign instr_valid = (state_q == ST_ISSUE);
   assign busy        = (state_q == ST_FETCH) || (state_q == ST_ISSUE) ||
                        (state_q == ST_HOLD);
   assign timeout_err = (state_q == ST_ERROR);
   assign pc          = pc_q;
   assign imem_addr   = pc_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_sequencer
//
// Directed bench for pc_fetch_sequencer (ADDR_W=5, RESET_PC=0, MAX_WAIT=15).
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

   localparam int ADDR_W = 5;

   logic              clk;
   logic              reset;
   logic              start;
   logic              halt;
   logic              stall;
   logic              br_taken;
   logic [ADDR_W-1:0] br_target;
   logic              imem_ack;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic [ADDR_W-1:0] pc;
   logic              instr_valid;
   logic              busy;
   logic              timeout_err;

   int n_cmp;
   int n_bad;

   pc_fetch_sequencer #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (5'd0),
      .MAX_WAIT (15)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .halt        (halt),
      .stall       (stall),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .imem_ack    (imem_ack),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .pc          (pc),
      .instr_valid (instr_valid),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expects to be in FETCH at address a; acks in the same cycle and checks
   // the ISSUE cycle that follows. Leaves the bench sitting in ISSUE.
   task automatic do_fetch(input int a);
      chk($sformatf("req@%0d", a), 32'(imem_req), 1);
      chk($sformatf("addr@%0d", a), 32'(imem_addr), 32'(a));
      chk($sformatf("novalid_fetch@%0d", a), 32'(instr_valid), 0);
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      chk($sformatf("valid@%0d", a), 32'(instr_valid), 1);
      chk($sformatf("noreq_issue@%0d", a), 32'(imem_req), 0);
      chk($sformatf("pc_issue@%0d", a), 32'(pc), 32'(a));
      chk($sformatf("busy_issue@%0d", a), 32'(busy), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      reset     = 1'b0;
      start     = 1'b0;
      halt      = 1'b0;
      stall     = 1'b0;
      br_taken  = 1'b0;
      br_target = '0;
      imem_ack  = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_req", 32'(imem_req), 0);
      chk("rst_valid", 32'(instr_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_timeout", 32'(timeout_err), 0);
      chk("rst_pc", 32'(pc), 0);
      reset = 1'b1;
      tick();
      chk("idle_busy", 32'(busy), 0);

      // 1: start, then same-cycle acks at 0,1,2,3
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_busy", 32'(busy), 1);
      do_fetch(0);
      tick();
      do_fetch(1);
      tick();
      do_fetch(2);
      tick();
      do_fetch(3);

      // 2: branch from ISSUE at pc=3 to 20
      br_taken  = 1'b1;
      br_target = 5'd20;
      tick();
      br_taken  = 1'b0;
      do_fetch(20);

      // 3: sequential run through 31 and wrap to 0
      for (int a = 21; a <= 31; a++) begin
         tick();
         do_fetch(a);
      end
      tick();
      do_fetch(0);
      chk("wrap_no_err", 32'(timeout_err), 0);
      for (int a = 1; a <= 4; a++) begin
         tick();
         do_fetch(a);
      end

      // 4: stall for 3 cycles from ISSUE at pc=4
      stall = 1'b1;
      tick();
      chk("hold1_req", 32'(imem_req), 0);
      chk("hold1_valid", 32'(instr_valid), 0);
      chk("hold1_busy", 32'(busy), 1);
      chk("hold1_pc", 32'(pc), 4);
      tick();
      chk("hold2_req", 32'(imem_req), 0);
      chk("hold2_valid", 32'(instr_valid), 0);
      tick();
      chk("hold3_req", 32'(imem_req), 0);
      chk("hold3_pc", 32'(pc), 4);
      stall = 1'b0;
      tick();
      do_fetch(5);

      // Branch taken while stalled wins over the stall
      stall = 1'b1;
      tick();
      chk("hold_b_req", 32'(imem_req), 0);
      br_taken  = 1'b1;
      br_target = 5'd9;
      tick();
      br_taken = 1'b0;
      stall    = 1'b0;
      do_fetch(9);

      // 6: halt and branch together in ISSUE -> HALTED, pc unchanged
      halt      = 1'b1;
      br_taken  = 1'b1;
      br_target = 5'd17;
      tick();
      halt     = 1'b0;
      br_taken = 1'b0;
      chk("halted_busy", 32'(busy), 0);
      chk("halted_pc", 32'(pc), 9);
      chk("halted_req", 32'(imem_req), 0);
      chk("halted_valid", 32'(instr_valid), 0);
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      chk("halted_ack_ignored", 32'(busy), 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      do_fetch(0);
      tick();
      chk("pre_rst_req", 32'(imem_req), 1);
      chk("pre_rst_addr", 32'(imem_addr), 1);
      // Asynchronous reset mid-FETCH drops the request without a clock edge
      reset = 1'b0;
      #1;
      chk("async_rst_req", 32'(imem_req), 0);
      chk("async_rst_busy", 32'(busy), 0);
      chk("async_rst_pc", 32'(pc), 0);
      reset = 1'b1;
      tick();

      // 5: no ack -> request held for 15 cycles, then ERROR
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         chk($sformatf("wait_req_%0d", i), 32'(imem_req), 1);
         tick();
      end
      chk("to_req", 32'(imem_req), 0);
      chk("to_err", 32'(timeout_err), 1);
      chk("to_busy", 32'(busy), 0);
      start    = 1'b1;
      imem_ack = 1'b1;
      tick();
      tick();
      start    = 1'b0;
      imem_ack = 1'b0;
      chk("err_start_ignored_req", 32'(imem_req), 0);
      chk("err_sticky", 32'(timeout_err), 1);
      chk("err_busy", 32'(busy), 0);
      reset = 1'b0;
      tick();
      chk("err_cleared", 32'(timeout_err), 0);
      reset = 1'b1;
      tick();
      chk("post_err_idle", 32'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
